not_gate_checker: RTL

NOT_GATE_CHECKER -- requirements
Module: not_gate_checker

---
 rtl/not_chk_pkg.sv | 18 +
 rtl/chk_settle_timer.sv | 28 ++
 rtl/not_gate_checker.sv | 132 +++++++++++++
 3 files changed

// File: rtl/not_chk_pkg.sv
// Shared definitions for the NOT-gate checker: state encoding, default parameters
// and the settle timer width.
package not_chk_pkg;

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_ARMED   = 3'd1,
    S_SETTLE  = 3'd2,
    S_COMPARE = 3'd3,
    S_DONE    = 3'd4
  } chk_state_e;

  localparam int unsigned DEF_SETTLE_CYC = 2;
  localparam int unsigned DEF_CNT_W      = 8;
  // Wide enough for the largest legal settle time (15).
  localparam int unsigned TMR_W          = 4;

endpackage

// File: rtl/chk_settle_timer.sv
// Settle countdown: load at vector accept, count down while settling,
// expire on the final settle cycle.
module chk_settle_timer
  import not_chk_pkg::*;
#(
  parameter int unsigned SETTLE_CYC = DEF_SETTLE_CYC
) (
  input  logic clk,
  input  logic rst_n,
  input  logic load,
  input  logic count,
  output logic expire
);

  // Loading SETTLE_CYC-1 makes expire fire in the SETTLE_CYC-th settle cycle.
  localparam logic [TMR_W-1:0] LOAD_VAL = TMR_W'(SETTLE_CYC - 1);

  logic [TMR_W-1:0] cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                     cnt <= '0;
    else if (load)                  cnt <= LOAD_VAL;
    else if (count && cnt != '0)    cnt <= cnt - 1'b1;
  end

  assign expire = count && (cnt == '0);

endmodule

// File: rtl/not_gate_checker.sv
// Sequences test vectors into a NOT gate and judges its response after a settle
// delay. Optional first-fail capture is enabled by defining CHK_FAIL_CAPTURE_EN.
module not_gate_checker
  import not_chk_pkg::*;
#(
  parameter int unsigned SETTLE_CYC = DEF_SETTLE_CYC,
  parameter int unsigned CNT_W      = DEF_CNT_W
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             vec_valid,
  input  logic             vec_a,
  input  logic             vec_last,
  input  logic             dut_y,
  output logic             vec_ready,
  output logic             busy,
  output logic             done,
  output logic [CNT_W-1:0] pass_cnt,
  output logic [CNT_W-1:0] fail_cnt,
  output logic             err
`ifdef CHK_FAIL_CAPTURE_EN
  ,
  output logic [CNT_W-1:0] first_fail_idx,
  output logic             first_fail_a
`endif
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  chk_state_e state;
  logic       a_q;
  logic       last_q;
  logic       accept;
  logic       tmr_expire;

  assign accept = vec_valid && vec_ready;

  chk_settle_timer #(.SETTLE_CYC(SETTLE_CYC)) u_timer (
    .clk    (clk),
    .rst_n  (rst_n),
    .load   (accept),
    .count  (state == S_SETTLE),
    .expire (tmr_expire)
  );

`ifdef CHK_FAIL_CAPTURE_EN
  logic [CNT_W-1:0] vec_idx;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vec_idx        <= '0;
      first_fail_idx <= '0;
      first_fail_a   <= 1'b0;
    end else if (start) begin
      vec_idx        <= '0;
      first_fail_idx <= '0;
      first_fail_a   <= 1'b0;
    end else if (state == S_COMPARE) begin
      if (vec_idx != CNT_MAX) vec_idx <= vec_idx + 1'b1;
      // err is still low on the first failing compare of a run.
      if (dut_y == a_q && !err) begin
        first_fail_idx <= vec_idx;
        first_fail_a   <= a_q;
      end
    end
  end
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= S_IDLE;
      vec_ready <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      err       <= 1'b0;
      pass_cnt  <= '0;
      fail_cnt  <= '0;
      a_q       <= 1'b0;
      last_q    <= 1'b0;
    end else if (start) begin
      // Start from any state, including mid-run: in-flight vector is dropped.
      state     <= S_ARMED;
      vec_ready <= 1'b1;
      busy      <= 1'b1;
      done      <= 1'b0;
      err       <= 1'b0;
      pass_cnt  <= '0;
      fail_cnt  <= '0;
      a_q       <= 1'b0;
      last_q    <= 1'b0;
    end else begin
      case (state)
        S_ARMED: begin
          if (accept) begin
            a_q       <= vec_a;
            last_q    <= vec_last;
            vec_ready <= 1'b0;
            state     <= S_SETTLE;
          end
        end
        S_SETTLE: begin
          if (tmr_expire) state <= S_COMPARE;
        end
        S_COMPARE: begin
          if (dut_y == ~a_q) begin
            if (pass_cnt != CNT_MAX) pass_cnt <= pass_cnt + 1'b1;
          end else begin
            if (fail_cnt != CNT_MAX) fail_cnt <= fail_cnt + 1'b1;
            err <= 1'b1;
          end
          if (last_q) begin
            state <= S_DONE;
            busy  <= 1'b0;
            done  <= 1'b1;
          end else begin
            state     <= S_ARMED;
            vec_ready <= 1'b1;
          end
        end
        S_IDLE, S_DONE: ;
        default: begin
          state     <= S_IDLE;
          vec_ready <= 1'b0;
          busy      <= 1'b0;
          done      <= 1'b0;
        end
      endcase
    end
  end

endmodule
